branch_ctrl: RTL and testbench
==============================

// Module: branch_ctrl
// PURPOSE
//  Sequences branch resolution in the ID stage of the 5-stage MIPS pipeline. Takes the flags
//  of the ID-stage branch comparator (equal/bgez/bgtz/bltz/blez of RD1,RD2), stalls IF/ID
//  while branch operands are not yet forwardable, and issues the taken/not-taken decision
//  to PC select. Keeps per-run branch statistics and flags operands that never become ready.
// PARAMETERS
//  CNT_W     32  width of statistics counters branch_cnt / taken_cnt
//  MAX_WAIT  3   stall cycles allowed before wait_err is raised
// PORTS
//  clk         in   1      clock, all state updates on rising edge
//  reset       in   1      synchronous, active-high
//  br_valid    in   1      ID stage holds a branch instruction
//  br_type     in   3      0 BEQ,1 BNE,2 BGEZ,3 BGTZ,4 BLTZ,5 BLEZ; 6,7 reserved
//  rs_ready    in   1      RD1 value is correct this cycle (via regfile or forward)
//  rt_ready    in   1      RD2 value is correct this cycle
//  flush       in   1      pipeline flush (exception); aborts a pending branch
//  equal_in    in   1      comparator: RD1==RD2
//  bgez_in     in   1      comparator: $signed(RD1)>=0
//  bgtz_in     in   1      comparator: $signed(RD1)>0
//  bltz_in     in   1      comparator: $signed(RD1)<0
//  blez_in     in   1      comparator: $signed(RD1)<=0
//  stall       out  1      freeze PC and IF/ID, bubble into ID/EX
//  br_taken    out  1      1-cycle pulse: select branch target for PC
//  br_done     out  1      1-cycle pulse: branch resolved (taken or not)
//  wait_err    out  1      sticky: a branch stalled more than MAX_WAIT cycles
//  branch_cnt  out  CNT_W  resolved branches since reset
//  taken_cnt   out  CNT_W  resolved taken branches since reset
// BEHAVIOUR
//  - ops_ready = rs_ready & (rt_ready | br_type>=2); BEQ/BNE need both, others only rs.
//  - cond: BEQ equal_in, BNE !equal_in, BGEZ bgez_in, BGTZ bgtz_in, BLTZ bltz_in,
//    BLEZ blez_in; types 6,7 -> cond=0 (resolved not-taken, still counted).
//  - States: IDLE, WAIT. wait_cnt register, 0..MAX_WAIT, saturating.
//  - IDLE: br_valid & !flush & ops_ready -> resolve (same cycle, Mealy), stay IDLE.
//    br_valid & !flush & !ops_ready -> stall=1, ->WAIT, wait_cnt<=1.
//  - WAIT: stall=1 while !ops_ready. ops_ready & br_valid & !flush -> resolve, stall=0,
//    ->IDLE, wait_cnt<=0. !ops_ready: wait_cnt<=wait_cnt+1 (saturate); if wait_cnt==MAX_WAIT
//    in this cycle, wait_err<=1, keep stalling (no forced decision).
//  - resolve cycle: br_done=1, br_taken=cond; at edge branch_cnt+=1, taken_cnt+=cond.
//  - flush wins over everything: stall=0, br_taken=0, br_done=0, no count, ->IDLE, wait_cnt<=0.
//  - br_valid falls in WAIT without flush: ->IDLE, no count, stall=0 that cycle.
//  - Counters wrap modulo 2^CNT_W; wait_err cleared only by reset.
//  - stall/br_taken/br_done gated by !reset (0 during reset cycle).
//  - Reset: state IDLE, wait_cnt 0, wait_err 0, branch_cnt 0, taken_cnt 0;
//    stall 0, br_taken 0, br_done 0.
//  - Latency: 0 cycles when ready in IDLE; N stall cycles when operands arrive after N cycles.
//  - Delay slot is not flushed by this block; PC logic handles it.
// TESTING
//  BEQ, rs/rt ready, equal_in=1 -> same cycle br_taken=1, br_done=1, stall=0; next taken_cnt=1.
//  BNE, rt_ready=0 for 2 cycles then 1, equal_in=1 -> stall=1 for 2 cycles, then br_done=1,
//   br_taken=0; branch_cnt+1, taken_cnt unchanged.
//  BLTZ, rt_ready=0 forever, rs_ready=1, bltz_in=1 -> no stall, br_taken=1 (rt ignored).
//  rs_ready=0 for 5 cycles, MAX_WAIT=3 -> stall held 5 cycles, wait_err=1 from 4th edge, sticky.
//  flush asserted in same cycle ops_ready rises in WAIT -> br_taken=0, no count, state IDLE.
//  CNT_W=4, 16 taken BGEZ -> taken_cnt wraps 15->0; reset mid-WAIT -> all outputs/counters 0.

Source files
------------

// File: rtl/branch_ctrl.sv
// Branch resolution sequencer for the ID stage: stalls IF/ID until the branch
// operands are forwardable, issues the taken/not-taken decision to PC select,
// keeps resolved/taken statistics and flags operands that never arrive.
module branch_ctrl #(
   parameter int unsigned CNT_W    = 32,
   parameter int unsigned MAX_WAIT = 3
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             br_valid,
   input  logic [2:0]       br_type,
   input  logic             rs_ready,
   input  logic             rt_ready,
   input  logic             flush,
   input  logic             equal_in,
   input  logic             bgez_in,
   input  logic             bgtz_in,
   input  logic             bltz_in,
   input  logic             blez_in,
   output logic             stall,
   output logic             br_taken,
   output logic             br_done,
   output logic             wait_err,
   output logic [CNT_W-1:0] branch_cnt,
   output logic [CNT_W-1:0] taken_cnt
);

   // Wait counter just wide enough to hold 0..MAX_WAIT
   localparam int unsigned WC_W = (MAX_WAIT < 2) ? 1 : $clog2(MAX_WAIT + 1);
   localparam logic [WC_W-1:0] WC_MAX   = WC_W'(MAX_WAIT);
   localparam logic [WC_W-1:0] WC_FIRST = (MAX_WAIT == 0) ? '0 : WC_W'(1);

   localparam logic [2:0] T_BEQ  = 3'd0;
   localparam logic [2:0] T_BNE  = 3'd1;
   localparam logic [2:0] T_BGEZ = 3'd2;
   localparam logic [2:0] T_BGTZ = 3'd3;
   localparam logic [2:0] T_BLTZ = 3'd4;
   localparam logic [2:0] T_BLEZ = 3'd5;

   typedef enum logic {
      IDLE = 1'b0,
      WAIT = 1'b1
   } state_t;

   state_t          state_q, state_d;
   logic [WC_W-1:0] wait_cnt_q, wait_cnt_d;
   logic            wait_err_d;
   logic            ops_ready;
   logic            cond;

   // Operand readiness and branch condition from the comparator flags
   always_comb begin
      ops_ready = rs_ready & (rt_ready | (br_type >= T_BGEZ));
      unique case (br_type)
         T_BEQ:   cond = equal_in;
         T_BNE:   cond = ~equal_in;
         T_BGEZ:  cond = bgez_in;
         T_BGTZ:  cond = bgtz_in;
         T_BLTZ:  cond = bltz_in;
         T_BLEZ:  cond = blez_in;
         default: cond = 1'b0;
      endcase
   end

   // Next state, wait tracking and the same-cycle stall/resolve outputs
   always_comb begin
      state_d    = state_q;
      wait_cnt_d = wait_cnt_q;
      wait_err_d = wait_err;
      stall      = 1'b0;
      br_taken   = 1'b0;
      br_done    = 1'b0;
      if (reset) begin
         state_d    = IDLE;
         wait_cnt_d = '0;
      end else if (flush) begin
         // Exception flush aborts any pending branch without counting it
         state_d    = IDLE;
         wait_cnt_d = '0;
      end else begin
         unique case (state_q)
            IDLE: begin
               if (br_valid) begin
                  if (ops_ready) begin
                     br_done  = 1'b1;
                     br_taken = cond;
                  end else begin
                     stall      = 1'b1;
                     state_d    = WAIT;
                     wait_cnt_d = WC_FIRST;
                  end
               end
            end
            WAIT: begin
               if (!br_valid) begin
                  // Branch left ID without resolving here; drop it
                  state_d    = IDLE;
                  wait_cnt_d = '0;
               end else if (ops_ready) begin
                  br_done    = 1'b1;
                  br_taken   = cond;
                  state_d    = IDLE;
                  wait_cnt_d = '0;
               end else begin
                  // Keep stalling; no forced decision on timeout
                  stall = 1'b1;
                  if (wait_cnt_q == WC_MAX) begin
                     wait_err_d = 1'b1;
                  end else begin
                     wait_cnt_d = wait_cnt_q + WC_W'(1);
                  end
               end
            end
            default: begin
               state_d    = IDLE;
               wait_cnt_d = '0;
            end
         endcase
      end
   end

   // State, wait counter and sticky timeout flag
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= IDLE;
         wait_cnt_q <= '0;
         wait_err   <= 1'b0;
      end else begin
         state_q    <= state_d;
         wait_cnt_q <= wait_cnt_d;
         wait_err   <= wait_err_d;
      end
   end

   // Resolved / taken branch statistics, wrapping modulo 2^CNT_W
   always_ff @(posedge clk) begin
      if (reset) begin
         branch_cnt <= '0;
         taken_cnt  <= '0;
      end else if (br_done) begin
         branch_cnt <= branch_cnt + CNT_W'(1);
         taken_cnt  <= taken_cnt + CNT_W'(br_taken);
      end
   end

endmodule

// File: tb/tb_branch_ctrl.sv
// Bench for branch_ctrl: directed scenarios with literal expectations plus
// randomized traffic, all checked every cycle against a behavioural model.
module tb_branch_ctrl;

   localparam int unsigned MAX_WAIT = 3;

   logic        clk;
   logic        reset;
   logic        br_valid;
   logic [2:0]  br_type;
   logic        rs_ready, rt_ready, flush;
   logic        equal_in, bgez_in, bgtz_in, bltz_in, blez_in;

   logic        stall, br_taken, br_done, wait_err;
   logic [31:0] branch_cnt, taken_cnt;
   logic        stall4, br_taken4, br_done4, wait_err4;
   logic [3:0]  branch_cnt4, taken_cnt4;

   int checks = 0;
   int errors = 0;

   // Model state: counters, sticky error, length of the current stall run
   logic [31:0] m_bcnt = '0;
   logic [31:0] m_tcnt = '0;
   logic        m_err  = 1'b0;
   int          m_run  = 0;

   branch_ctrl #(.CNT_W(32), .MAX_WAIT(MAX_WAIT)) u_dut (
      .clk(clk), .reset(reset), .br_valid(br_valid), .br_type(br_type),
      .rs_ready(rs_ready), .rt_ready(rt_ready), .flush(flush),
      .equal_in(equal_in), .bgez_in(bgez_in), .bgtz_in(bgtz_in),
      .bltz_in(bltz_in), .blez_in(blez_in),
      .stall(stall), .br_taken(br_taken), .br_done(br_done),
      .wait_err(wait_err), .branch_cnt(branch_cnt), .taken_cnt(taken_cnt)
   );

   branch_ctrl #(.CNT_W(4), .MAX_WAIT(MAX_WAIT)) u_dut4 (
      .clk(clk), .reset(reset), .br_valid(br_valid), .br_type(br_type),
      .rs_ready(rs_ready), .rt_ready(rt_ready), .flush(flush),
      .equal_in(equal_in), .bgez_in(bgez_in), .bgtz_in(bgtz_in),
      .bltz_in(bltz_in), .blez_in(blez_in),
      .stall(stall4), .br_taken(br_taken4), .br_done(br_done4),
      .wait_err(wait_err4), .branch_cnt(branch_cnt4), .taken_cnt(taken_cnt4)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
      end
   endtask

   // Compare both DUTs against the model, then advance the model past the edge
   task automatic model_check();
      logic       ops, cond, ex_stall, ex_done;
      logic [7:0] flags;
      ops      = rs_ready & (rt_ready | (br_type >= 3'd2));
      flags    = {2'b00, blez_in, bltz_in, bgtz_in, bgez_in, ~equal_in, equal_in};
      cond     = flags[br_type];
      ex_done  = ~reset & br_valid & ~flush & ops;
      ex_stall = ~reset & br_valid & ~flush & ~ops;
      chk("m_stall",  32'(stall),    32'(ex_stall));
      chk("m_done",   32'(br_done),  32'(ex_done));
      chk("m_taken",  32'(br_taken), 32'(ex_done & cond));
      chk("m_err",    32'(wait_err), 32'(m_err));
      chk("m_bcnt",   branch_cnt,    m_bcnt);
      chk("m_tcnt",   taken_cnt,     m_tcnt);
      chk("m_stall4", 32'(stall4),   32'(ex_stall));
      chk("m_taken4", 32'(br_taken4), 32'(ex_done & cond));
      chk("m_err4",   32'(wait_err4), 32'(m_err));
      chk("m_bcnt4",  32'(branch_cnt4), 32'(m_bcnt[3:0]));
      chk("m_tcnt4",  32'(taken_cnt4),  32'(m_tcnt[3:0]));
      if (reset) begin
         m_bcnt = '0;
         m_tcnt = '0;
         m_err  = 1'b0;
         m_run  = 0;
      end else if (ex_done) begin
         m_bcnt = m_bcnt + 32'd1;
         m_tcnt = m_tcnt + 32'(cond);
         m_run  = 0;
      end else if (ex_stall) begin
         m_run = m_run + 1;
         if (m_run > int'(MAX_WAIT)) m_err = 1'b1;
      end else begin
         m_run = 0;
      end
   endtask

   task automatic smp();
      @(negedge clk);
      model_check();
   endtask

   task automatic nxt();
      @(posedge clk);
      #1;
   endtask

   initial begin
      reset = 1'b1; br_valid = 1'b0; br_type = 3'd0; rs_ready = 1'b0; rt_ready = 1'b0;
      flush = 1'b0; equal_in = 1'b0; bgez_in = 1'b0; bgtz_in = 1'b0; bltz_in = 1'b0;
      blez_in = 1'b0;
      nxt();

      // Outputs gated during reset even with a ready branch present
      br_valid = 1'b1; rs_ready = 1'b1; rt_ready = 1'b1; equal_in = 1'b1;
      smp();
      chk("rst_stall", 32'(stall), 32'd0);
      chk("rst_done",  32'(br_done), 32'd0);
      chk("rst_taken", 32'(br_taken), 32'd0);
      chk("rst_bcnt",  branch_cnt, 32'd0);
      chk("rst_err",   32'(wait_err), 32'd0);
      nxt(); reset = 1'b0;

      // BEQ ready and equal: resolves taken in the same cycle
      smp();
      chk("beq_taken", 32'(br_taken), 32'd1);
      chk("beq_done",  32'(br_done), 32'd1);
      chk("beq_stall", 32'(stall), 32'd0);
      nxt(); br_valid = 1'b0;
      smp();
      chk("beq_tcnt", taken_cnt, 32'd1);
      chk("beq_bcnt", branch_cnt, 32'd1);

      // BNE with rt late by two cycles, equal: not taken after 2 stalls
      nxt(); br_valid = 1'b1; br_type = 3'd1; rt_ready = 1'b0;
      smp(); chk("bne_stall1", 32'(stall), 32'd1);
      nxt();
      smp(); chk("bne_stall2", 32'(stall), 32'd1);
      nxt(); rt_ready = 1'b1;
      smp();
      chk("bne_done",  32'(br_done), 32'd1);
      chk("bne_taken", 32'(br_taken), 32'd0);
      chk("bne_stall", 32'(stall), 32'd0);
      nxt(); br_valid = 1'b0;
      smp();
      chk("bne_bcnt", branch_cnt, 32'd2);
      chk("bne_tcnt", taken_cnt, 32'd1);

      // BLTZ ignores rt readiness
      nxt(); br_valid = 1'b1; br_type = 3'd4; rt_ready = 1'b0; equal_in = 1'b0; bltz_in = 1'b1;
      smp();
      chk("bltz_stall", 32'(stall), 32'd0);
      chk("bltz_taken", 32'(br_taken), 32'd1);
      nxt(); br_valid = 1'b0;
      smp();
      chk("bltz_bcnt", branch_cnt, 32'd3);
      chk("bltz_tcnt", taken_cnt, 32'd2);

      // rs never ready for 5 cycles: wait_err visible after the 4th edge, sticky
      nxt(); br_valid = 1'b1; br_type = 3'd2; rs_ready = 1'b0; rt_ready = 1'b1;
      for (int i = 1; i <= 5; i++) begin
         smp();
         chk("to_stall", 32'(stall), 32'd1);
         if (i == 4) chk("to_err_pre", 32'(wait_err), 32'd0);
         if (i == 5) chk("to_err_set", 32'(wait_err), 32'd1);
         nxt();
      end
      br_valid = 1'b0; rs_ready = 1'b1;
      smp();
      chk("to_err_sticky", 32'(wait_err), 32'd1);
      chk("to_stall_off",  32'(stall), 32'd0);

      // Flush in the cycle operands arrive in WAIT: nothing resolved
      nxt(); br_valid = 1'b1; br_type = 3'd0; rs_ready = 1'b0; equal_in = 1'b1;
      smp(); chk("fl_stall_pre", 32'(stall), 32'd1);
      nxt(); rs_ready = 1'b1; flush = 1'b1;
      smp();
      chk("fl_taken", 32'(br_taken), 32'd0);
      chk("fl_done",  32'(br_done), 32'd0);
      chk("fl_stall", 32'(stall), 32'd0);
      nxt(); flush = 1'b0; br_valid = 1'b0;
      smp(); chk("fl_bcnt", branch_cnt, 32'd3);

      // Reserved type: counted, never taken
      nxt(); br_valid = 1'b1; br_type = 3'd7;
      bgez_in = 1'b1; bgtz_in = 1'b1; bltz_in = 1'b1; blez_in = 1'b1;
      smp();
      chk("rsv_done",  32'(br_done), 32'd1);
      chk("rsv_taken", 32'(br_taken), 32'd0);
      nxt(); br_valid = 1'b0;
      smp();
      chk("rsv_bcnt", branch_cnt, 32'd4);
      chk("rsv_tcnt", taken_cnt, 32'd2);

      // 16 taken BGEZ: 4-bit taken counter wraps 15 -> 0
      nxt(); br_valid = 1'b1; br_type = 3'd2;
      for (int i = 0; i < 16; i++) begin
         smp();
         if (i == 13) chk("wrap_15", 32'(taken_cnt4), 32'd15);
         if (i == 14) chk("wrap_0",  32'(taken_cnt4), 32'd0);
         nxt();
      end
      br_valid = 1'b0;
      smp();
      chk("wrap_tcnt4", 32'(taken_cnt4), 32'd2);
      chk("wrap_bcnt4", 32'(branch_cnt4), 32'd4);
      chk("wrap_tcnt",  taken_cnt, 32'd18);

      // Reset while stalled in WAIT clears everything
      nxt(); br_valid = 1'b1; br_type = 3'd0; rs_ready = 1'b0;
      smp(); chk("rmw_stall_pre", 32'(stall), 32'd1);
      nxt();
      smp();
      nxt(); reset = 1'b1;
      smp(); chk("rmw_stall", 32'(stall), 32'd0);
      nxt(); reset = 1'b0; br_valid = 1'b0;
      smp();
      chk("rmw_err",   32'(wait_err), 32'd0);
      chk("rmw_bcnt",  branch_cnt, 32'd0);
      chk("rmw_tcnt",  taken_cnt, 32'd0);
      chk("rmw_tcnt4", 32'(taken_cnt4), 32'd0);

      // Randomized traffic against the model
      for (int i = 0; i < 3000; i++) begin
         nxt();
         reset    = ($urandom_range(0, 199) == 0);
         br_valid = ($urandom_range(0, 3) != 0);
         br_type  = 3'($urandom_range(0, 7));
         rs_ready = ($urandom_range(0, 2) != 0);
         rt_ready = ($urandom_range(0, 2) != 0);
         flush    = ($urandom_range(0, 15) == 0);
         equal_in = 1'($urandom);
         bgez_in  = 1'($urandom);
         bgtz_in  = 1'($urandom);
         bltz_in  = 1'($urandom);
         blez_in  = 1'($urandom);
         smp();
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
